spi_bus_slave: RTL and testbench
================================

# spi_bus_slave

SPI responder that terminates the host's framed register protocol and drives the internal 14-bit-address / 16-bit-data peripheral bus (BRAM, UART, mic arrays, etc.). Each ss-low frame is one 16-bit header {addr[13:0], autoinc, RnW} followed by one or more 16-bit data words. Writes produce bus write strobes; reads fetch bus data and shift it out on miso. The block sits between the top-level SPI pins and the address decoder, in the clk_50 domain.

## Interface
- ADDR_W, 14, bus address width (header bits [15:2])
- DATA_W, 16, SPI word and bus data width
- SYNC_STAGES, 2, synchronizer depth for ss/sck/mosi
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-high reset (block resets while resetn=1)
- ss  in  1  slave select, active low, asynchronous to clk
- sck  in  1  SPI clock, idles high, asynchronous to clk
- mosi  in  1  host data, MSB first, changes while sck low
- miso  out  1  slave data, MSB first, updated on sck falling edge; 0 when idle
- bus_addr  out  ADDR_W  current word address
- bus_wr_data  out  DATA_W  write data, valid with bus_we
- bus_we  out  1  one-cycle write strobe
- bus_rd  out  1  one-cycle read strobe
- bus_rd_data  in  DATA_W  read data, valid exactly one clk after bus_rd

## Operation
- ss, sck, mosi pass through SYNC_STAGES flops; sck rise/fall detected on synchronized samples.
- States: IDLE -> HEADER on synchronized ss falling; HEADER -> DATA after 16th sck rise; DATA loops per word; any state -> IDLE when synchronized ss high.
- HEADER: shift mosi on each sck rise; on 16th bit latch addr=hdr[15:2], autoinc=hdr[1], rnw=hdr[0].
- Read (rnw=1): bus_rd pulses once on header completion at addr; captured data loads tx shift register; bit 15 appears on miso at first sck fall of the data word, subsequent bits on each later fall. After each data word's 16th sck rise: if autoinc, addr <= addr+1, then bus_rd reissued (prefetch for next word); if not autoinc, bus_rd reissued at same addr (FIFO-style register reads).
- Prefetch consequence: a read frame of N data words issues N+1 bus_rd strobes; the last is discarded. Documented; peripherals with read side effects must tolerate it.
- Write (rnw=0): mosi shifted per sck rise; after 16th bit, bus_we pulses one cycle with bus_wr_data=word, bus_addr=addr; addr increments in the following cycle if autoinc.
- Address arithmetic: ADDR_W-bit modulo; 0x3FFF+1 wraps to 0x0000.
- ss high mid-word: partial word discarded, no strobe, bit counter cleared, miso=0. ss high mid-header: nothing issued.
- Reset (resetn=1), including mid-frame: state IDLE, miso=0, bus_we=0, bus_rd=0, bus_addr=0, bus_wr_data=0, counters 0; a frame in progress is ignored until ss goes high and low again.

## Timing
- Input-to-detect latency: SYNC_STAGES+1 clk from pin edge to internal edge event.
- sck high and low phases each ≥1 clk; gap ≥2 clk between words; ss setup ≥2 clk before first sck fall.
- bus_rd asserts the clk after the edge event of the 16th sck rise; bus_rd_data registered the next clk; tx register loaded before the next word's first sck fall (≥2 clk margin with minimum spacing).
- bus_we asserts the clk after the edge event of the 16th data-bit sck rise, one cycle wide.
- miso updates the clk after a detected sck fall; host samples on sck rise.
- bus_rd and bus_we never asserted in the same cycle.

## Structure
- Shared package spi_bus_pkg: ADDR_W/DATA_W defaults, header field positions (ADDR_MSB=15, ADDR_LSB=2, AUTOINC_BIT=1, RNW_BIT=0), state enum {IDLE, HEADER, DATA}.
- One sub-module: spi_sync_edge (parameterized synchronizer + rise/fall detector), instantiated for sck and ss; mosi uses synchronizer only.

## Test plan
- Single write: header {0x0005,0,0}, data 0xA5A5 -> one bus_we, bus_addr=0x0005, bus_wr_data=0xA5A5; no bus_rd.
- Single read: bus returns 0x1234 for addr 0x1801; read frame -> miso shifts 0x1234 MSB first; two bus_rd strobes, both at 0x1801.
- Burst read autoinc: addr 0x1800, 17 data words, bus returns addr value -> host sees 0x1800..0x1810; bus_rd addresses 0x1800..0x1811.
- Burst write no autoinc: addr 0x0800, words 1..5 -> five bus_we at 0x0800 with data 1..5 in order.
- Wrap and abort: autoinc write at 0x3FFF, 2 words, ss high after 8 bits of third -> writes at 0x3FFF and 0x0000 only; no strobe for partial word; miso=0.
- Reset mid-frame: resetn=1 for one clk during data bit 10 of a write -> no bus_we, all outputs 0; next full frame completes correctly.

Source files
------------

// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI-to-peripheral-bus bridge: bus widths,
// header field layout and the framing state machine encoding.
package spi_bus_pkg;

    localparam int DEF_ADDR_W      = 14;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int ADDR_MSB    = 15;
    localparam int ADDR_LSB    = 2;
    localparam int AUTOINC_BIT = 1;
    localparam int RNW_BIT     = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall
// detection; level_o is aligned with the edge pulses.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q  <= {STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= STAGES'({sync_q, d_i});
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_bus_slave.sv
// SPI responder: decodes {addr, autoinc, rnw} headers and turns the following
// 16-bit words into peripheral-bus write strobes or prefetched reads.
module spi_bus_slave
    import spi_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ss,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    output logic              bus_we,
    output logic              bus_rd,
    input  logic [DATA_W-1:0] bus_rd_data
);

    localparam int CNT_W = $clog2(DATA_W);

    logic ss_level, ss_rise, ss_fall;
    logic sck_level, sck_rise, sck_fall;
    logic mosi_s;

    // ss resets to "low" so a frame already running at reset never produces a
    // falling edge; the host must raise ss first.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ss_sync (
        .clk     (clk),
        .srst    (resetn),
        .d_i     (ss),
        .level_o (ss_level),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
        .clk     (clk),
        .srst    (resetn),
        .d_i     (sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // One extra stage keeps mosi the same age as the registered sck edges.
    logic [SYNC_STAGES:0] mosi_sync_q;
    assign mosi_s = mosi_sync_q[SYNC_STAGES];

    logic unused_sync;
    assign unused_sync = &{1'b0, ss_rise, sck_level};

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q,   shift_d;
    logic [DATA_W-1:0]  tx_q,      tx_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic               autoinc_q, autoinc_d;
    logic               rnw_q,     rnw_d;
    logic               miso_q,    miso_d;
    logic               we_q,      we_d;
    logic               rd_q,      rd_d;
    logic               cap_q,     cap_d;
    logic               inc_q,     inc_d;

    logic [DATA_W-1:0]  word_in;
    logic               last_bit;

    assign word_in  = {shift_q[DATA_W-2:0], mosi_s};
    assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        wr_data_d = wr_data_q;
        addr_d    = addr_q;
        autoinc_d = autoinc_q;
        rnw_d     = rnw_q;
        miso_d    = miso_q;
        we_d      = 1'b0;
        rd_d      = 1'b0;
        cap_d     = rd_q;
        inc_d     = 1'b0;

        if (inc_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (ss_fall) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (sck_rise) begin
                    shift_d   = word_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        addr_d    = ADDR_W'(word_in[ADDR_MSB:ADDR_LSB]);
                        autoinc_d = word_in[AUTOINC_BIT];
                        rnw_d     = word_in[RNW_BIT];
                        rd_d      = word_in[RNW_BIT];
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (sck_fall && rnw_q) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (sck_rise) begin
                    shift_d   = word_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit && rnw_q) begin
                        // Prefetch the next word; autoinc steps first.
                        rd_d = 1'b1;
                        if (autoinc_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else if (last_bit) begin
                        we_d      = 1'b1;
                        wr_data_d = word_in;
                        inc_d     = autoinc_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_q) begin
            tx_d = bus_rd_data;
        end

        if (ss_level) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            wr_data_q   <= '0;
            addr_q      <= '0;
            autoinc_q   <= 1'b0;
            rnw_q       <= 1'b0;
            miso_q      <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            cap_q       <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            mosi_sync_q <= (SYNC_STAGES + 1)'({mosi_sync_q, mosi});
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            wr_data_q   <= wr_data_d;
            addr_q      <= addr_d;
            autoinc_q   <= autoinc_d;
            rnw_q       <= rnw_d;
            miso_q      <= miso_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            cap_q       <= cap_d;
            inc_q       <= inc_d;
        end
    end

    assign miso        = miso_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wr_data_q;
    assign bus_we      = we_q;
    assign bus_rd      = rd_q;

endmodule

// File: tb/tb_spi_bus_slave.sv
// Self-checking bench for spi_bus_slave: SPI host tasks, a registered bus read
// model, and queues of expected bus strobes checked as the DUT issues them.
module tb_spi_bus_slave;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ss = 1'b1;
    logic        sck = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [13:0] bus_addr;
    logic [15:0] bus_wr_data;
    logic        bus_we;
    logic        bus_rd;
    logic [15:0] bus_rd_data = 16'h0000;

    int checks = 0;
    int failures = 0;
    bit poke_en = 1'b0;

    logic [29:0] exp_wr_q[$];
    logic [13:0] exp_rd_q[$];

    spi_bus_slave dut (
        .clk         (clk),
        .resetn      (resetn),
        .ss          (ss),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_we      (bus_we),
        .bus_rd      (bus_rd),
        .bus_rd_data (bus_rd_data)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] rd_model(input logic [13:0] a);
        if (poke_en && a == 14'h1801) return 16'h1234;
        return {2'b00, a};
    endfunction

    // Read data is valid exactly one clk after bus_rd, garbage otherwise.
    always @(posedge clk) begin
        bus_rd_data <= bus_rd ? rd_model(bus_addr) : 16'hDEAD;
    end

    always @(negedge clk) begin
        logic [29:0] ew;
        logic [13:0] er;
        if (bus_we && bus_rd) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL strobe_overlap we=%b rd=%b required not both", bus_we, bus_rd);
        end
        if (bus_we) begin
            checks = checks + 1;
            $display("WR addr=%h data=%h", bus_addr, bus_wr_data);
            if (exp_wr_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_we got addr=%h data=%h required no write", bus_addr, bus_wr_data);
            end else begin
                ew = exp_wr_q.pop_front();
                if ({bus_addr, bus_wr_data} !== ew) begin
                    failures = failures + 1;
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             bus_addr, bus_wr_data, ew[29:16], ew[15:0]);
                end
            end
        end
        if (bus_rd) begin
            checks = checks + 1;
            $display("RD addr=%h", bus_addr);
            if (exp_rd_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_rd got addr=%h required no read", bus_addr);
            end else begin
                er = exp_rd_q.pop_front();
                if (bus_addr !== er) begin
                    failures = failures + 1;
                    $display("FAIL read_addr got %h required %h", bus_addr, er);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] hdr(input logic [13:0] a, input logic ai, input logic rnw);
        return {a, ai, rnw};
    endfunction

    task automatic spi_bits(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 15; i > 15 - nbits; i--) begin
            sck = 1'b0;
            mosi = tx[i];
            tick(HALF);
            rx[i] = miso;
            sck = 1'b1;
            tick(HALF);
        end
        tick(HALF);
    endtask

    task automatic frame_start();
        ss = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_stop();
        ss = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        tick(5);
        checks = checks + 5;
        if (bus_we !== 1'b0) begin failures = failures + 1; $display("FAIL reset_we got %b required 0", bus_we); end
        if (bus_rd !== 1'b0) begin failures = failures + 1; $display("FAIL reset_rd got %b required 0", bus_rd); end
        if (bus_addr !== 14'h0) begin failures = failures + 1; $display("FAIL reset_addr got %h required 0", bus_addr); end
        if (bus_wr_data !== 16'h0) begin failures = failures + 1; $display("FAIL reset_wr_data got %h required 0", bus_wr_data); end
        if (miso !== 1'b0) begin failures = failures + 1; $display("FAIL reset_miso got %b required 0", miso); end
        resetn = 1'b0;
        tick(5);
    endtask

    task automatic test_single_write();
        logic [15:0] rx;
        exp_wr_q.push_back({14'h0005, 16'hA5A5});
        frame_start();
        spi_bits(hdr(14'h0005, 1'b0, 1'b0), 16, rx);
        spi_bits(16'hA5A5, 16, rx);
        frame_stop();
        checks = checks + 2;
        if (exp_wr_q.size() != 0) begin failures = failures + 1; $display("FAIL single_write_missing got %0d pending required 0", exp_wr_q.size()); end
        if (bus_addr !== 14'h0005) begin failures = failures + 1; $display("FAIL single_write_addr got %h required 0005", bus_addr); end
    endtask

    task automatic test_single_read();
        logic [15:0] rx;
        poke_en = 1'b1;
        exp_rd_q.push_back(14'h1801);
        exp_rd_q.push_back(14'h1801);
        frame_start();
        spi_bits(hdr(14'h1801, 1'b0, 1'b1), 16, rx);
        spi_bits(16'h0000, 16, rx);
        $display("MISO word=%h", rx);
        frame_stop();
        checks = checks + 3;
        if (rx !== 16'h1234) begin failures = failures + 1; $display("FAIL single_read_miso got %h required 1234", rx); end
        if (exp_rd_q.size() != 0) begin failures = failures + 1; $display("FAIL single_read_strobes got %0d pending required 0", exp_rd_q.size()); end
        if (miso !== 1'b0) begin failures = failures + 1; $display("FAIL single_read_idle_miso got %b required 0", miso); end
        poke_en = 1'b0;
    endtask

    task automatic test_burst_read();
        logic [15:0] rx;
        for (int k = 0; k <= 17; k++) exp_rd_q.push_back(14'h1800 + 14'(k));
        frame_start();
        spi_bits(hdr(14'h1800, 1'b1, 1'b1), 16, rx);
        for (int k = 0; k < 17; k++) begin
            spi_bits(16'h0000, 16, rx);
            $display("MISO word=%h", rx);
            checks = checks + 1;
            if (rx !== 16'h1800 + 16'(k)) begin
                failures = failures + 1;
                $display("FAIL burst_read_word%0d got %h required %h", k, rx, 16'h1800 + 16'(k));
            end
        end
        frame_stop();
        checks = checks + 1;
        if (exp_rd_q.size() != 0) begin failures = failures + 1; $display("FAIL burst_read_strobes got %0d pending required 0", exp_rd_q.size()); end
    endtask

    task automatic test_burst_write_noinc();
        logic [15:0] rx;
        for (int k = 1; k <= 5; k++) exp_wr_q.push_back({14'h0800, 16'(k)});
        frame_start();
        spi_bits(hdr(14'h0800, 1'b0, 1'b0), 16, rx);
        for (int k = 1; k <= 5; k++) spi_bits(16'(k), 16, rx);
        frame_stop();
        checks = checks + 1;
        if (exp_wr_q.size() != 0) begin failures = failures + 1; $display("FAIL burst_write_missing got %0d pending required 0", exp_wr_q.size()); end
    endtask

    task automatic test_wrap_abort();
        logic [15:0] rx;
        exp_wr_q.push_back({14'h3FFF, 16'h1111});
        exp_wr_q.push_back({14'h0000, 16'h2222});
        frame_start();
        spi_bits(hdr(14'h3FFF, 1'b1, 1'b0), 16, rx);
        spi_bits(16'h1111, 16, rx);
        spi_bits(16'h2222, 16, rx);
        spi_bits(16'h3333, 8, rx);
        frame_stop();
        checks = checks + 3;
        if (exp_wr_q.size() != 0) begin failures = failures + 1; $display("FAIL wrap_missing got %0d pending required 0", exp_wr_q.size()); end
        if (bus_addr !== 14'h0001) begin failures = failures + 1; $display("FAIL wrap_addr got %h required 0001", bus_addr); end
        if (miso !== 1'b0) begin failures = failures + 1; $display("FAIL abort_miso got %b required 0", miso); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rx;
        logic [15:0] tx;
        tx = 16'hBEEF;
        frame_start();
        spi_bits(hdr(14'h0100, 1'b1, 1'b0), 16, rx);
        for (int i = 15; i >= 0; i--) begin
            sck = 1'b0;
            mosi = tx[i];
            tick(HALF);
            sck = 1'b1;
            if (i == 6) begin
                tick(1);
                resetn = 1'b1;
                tick(1);
                checks = checks + 5;
                if (bus_we !== 1'b0) begin failures = failures + 1; $display("FAIL midreset_we got %b required 0", bus_we); end
                if (bus_rd !== 1'b0) begin failures = failures + 1; $display("FAIL midreset_rd got %b required 0", bus_rd); end
                if (bus_addr !== 14'h0) begin failures = failures + 1; $display("FAIL midreset_addr got %h required 0", bus_addr); end
                if (bus_wr_data !== 16'h0) begin failures = failures + 1; $display("FAIL midreset_wr_data got %h required 0", bus_wr_data); end
                if (miso !== 1'b0) begin failures = failures + 1; $display("FAIL midreset_miso got %b required 0", miso); end
                resetn = 1'b0;
                tick(HALF - 2);
            end else begin
                tick(HALF);
            end
        end
        tick(HALF);
        spi_bits(16'h1357, 16, rx);
        frame_stop();
        exp_wr_q.push_back({14'h0123, 16'hCAFE});
        frame_start();
        spi_bits(hdr(14'h0123, 1'b0, 1'b0), 16, rx);
        spi_bits(16'hCAFE, 16, rx);
        frame_stop();
        checks = checks + 2;
        if (exp_wr_q.size() != 0) begin failures = failures + 1; $display("FAIL post_reset_write got %0d pending required 0", exp_wr_q.size()); end
        if (bus_addr !== 14'h0123) begin failures = failures + 1; $display("FAIL post_reset_addr got %h required 0123", bus_addr); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_read();
        test_burst_write_noinc();
        test_wrap_abort();
        test_reset_midframe();
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
